// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a one-entry stall buffer and redirect squashing.
// Redirects take effect only when decode is not stalled.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP      = 32'h83FF_F800
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ir_decode,
    output logic [31:0] pc_decode,
    output logic        decode_valid
);
    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] HOLD    = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [1:0]  state;
    logic        started;
    logic [31:0] pc, hold_buf, hold_pc, tgt, target;
    logic        take;

    function automatic logic [31:0] inc(input logic [31:0] p);
        return {p[31], p[30:0] + 31'd4};
    endfunction

    assign target    = redirect_pc & ~32'h3;
    assign take      = redirect & ~stall;
    assign imem_req  = started & (state != HOLD);
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FETCH;
            started      <= 1'b0;
            pc           <= RESET_PC & ~32'h3;
            ir_decode    <= NOP;
            pc_decode    <= RESET_PC;
            decode_valid <= 1'b0;
            hold_buf     <= '0;
            hold_pc      <= '0;
            tgt          <= '0;
        end else if (!started) begin
            started <= 1'b1;
        end else if (take) begin
            ir_decode    <= NOP;
            decode_valid <= 1'b0;
            tgt          <= target;
            // an unanswered request must drain before the new PC may be issued
            if (state != HOLD && !imem_ack) begin
                state <= DISCARD;
            end else begin
                pc    <= target;
                state <= FETCH;
            end
        end else if (state == HOLD) begin
            if (!stall) begin
                ir_decode    <= hold_buf;
                pc_decode    <= inc(hold_pc);
                decode_valid <= 1'b1;
                state        <= FETCH;
            end
        end else if (state == DISCARD) begin
            if (!stall) begin
                ir_decode    <= NOP;
                decode_valid <= 1'b0;
            end
            if (imem_ack) begin
                pc    <= tgt;
                state <= FETCH;
            end
        end else if (imem_ack) begin
            pc <= inc(pc);
            if (stall) begin
                hold_buf <= imem_data;
                hold_pc  <= pc;
                state    <= HOLD;
            end else begin
                ir_decode    <= imem_data;
                pc_decode    <= inc(pc);
                decode_valid <= 1'b1;
            end
        end else if (!stall) begin
            ir_decode    <= NOP;
            decode_valid <= 1'b0;
        end
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: imem_req  out  1  instruction fetch request.
REQ-004 SHALL have port: imem_addr  out  32  fetch address, word aligned.
REQ-005 SHALL have port: imem_ack  in  1  fetch completes, imem_data valid this cycle.
REQ-006 SHALL have port: imem_data  in  32  fetched instruction.
REQ-007 SHALL have port: stall  in  1  decode stage cannot accept (register-file load hazard).
REQ-008 SHALL have port: redirect  in  1  decode resolved a taken branch/jump.
REQ-009 SHALL have port: redirect_pc  in  32  branch/jump target.
REQ-010 SHALL have port: ir_decode  out  32  instruction presented to decode.
REQ-011 SHALL have port: pc_decode  out  32  PC+4 of ir_decode.
REQ-012 SHALL have port: decode_valid  out  1  ir_decode is a real instruction, not a bubble.
REQ-013 SHALL have parameters: RESET_PC, default 32'h8000_0000, reset vector; NOP, default 32'h83FF_F800, bubble encoding ADD(R31,R31,R31).

Function
REQ-014 SHALL implement states FETCH, HOLD, DISCARD.
REQ-015 SHALL drive imem_addr = pc; pc[1:0] always 0.
REQ-016 SHALL assert imem_req in FETCH and DISCARD; deassert in HOLD and during reset.
REQ-017 SHALL hold imem_addr stable while imem_req=1 and imem_ack=0.
REQ-018 PC increment SHALL be pc <= {pc[31], pc[30:0]+4}; bit 31 preserved, low 31 bits wrap.
REQ-019 FETCH, ack=1, stall=0, redirect=0: ir_decode<=imem_data, pc_decode<=pc+4, decode_valid<=1, pc<=pc+4, stay FETCH (back-to-back fetch, 1 instr/cycle max).
REQ-020 FETCH, ack=0, stall=0, redirect=0: ir_decode<=NOP, decode_valid<=0, pc_decode unchanged.
REQ-021 stall=1: ir_decode, pc_decode, decode_valid unchanged this cycle.
REQ-022 FETCH, ack=1, stall=1: imem_data captured into hold buffer, pc<=pc+4, go HOLD.
REQ-023 HOLD, stall=0, redirect=0: buffer -> ir_decode, pc_decode<=buffered PC+4, decode_valid<=1, go FETCH.
REQ-024 redirect SHALL be honoured only when stall=0; redirect with stall=1 ignored.
REQ-025 Honoured redirect: pc<={redirect_pc[31:2],2'b00}, ir_decode<=NOP, decode_valid<=0; highest priority over ack and hold buffer.
REQ-026 Redirect in FETCH with ack=1, or in HOLD: fetched/buffered instruction discarded, next state FETCH at new pc.
REQ-027 Redirect in FETCH with ack=0: go DISCARD; imem_addr stays at old address, target saved in redirect register.
REQ-028 DISCARD: keep imem_req; on ack drop imem_data, pc<=saved target, go FETCH; decode outputs NOP/valid 0 while stall=0.
REQ-029 Redirect arriving in DISCARD SHALL overwrite the saved target.
REQ-030 At most one fetch outstanding; no instruction SHALL be presented twice or skipped.

Reset
REQ-031 reset=1 SHALL immediately force pc=RESET_PC, state FETCH, imem_req=0, ir_decode=NOP, pc_decode=RESET_PC, decode_valid=0, hold buffer and redirect target cleared.
REQ-032 First imem_req SHALL assert the cycle after reset deasserts; reset mid-fetch abandons the outstanding request, its ack ignored.

Verification
REQ-033 Reset release, ack every cycle, data 0xA,0xB,0xC -> imem_addr 0x80000000,04,08; ir_decode 0xA,0xB,0xC with pc_decode 0x80000004,08,0C.
REQ-034 Ack on fetch of 0x80000004 while stall=1 for 3 cycles -> imem_req low 3 cycles, ir_decode unchanged, then that word appears, next fetch 0x80000008.
REQ-035 Redirect to 0x00000103 with ack same cycle -> ir_decode=NOP/valid 0, next imem_addr 0x00000100, acked data dropped.
REQ-036 Redirect to 0x200 while fetch pending, ack two cycles later -> imem_addr old value until ack, that data dropped, then imem_addr 0x200.
REQ-037 pc=0x7FFFFFFC fetch acked -> next pc 0x00000000; pc=0xFFFFFFFC -> 0x80000000.
REQ-038 reset asserted with fetch outstanding -> outputs at reset values same cycle; stray ack during reset ignored.
